// File: rtl/ram_rd_stream.sv
// Streams a (start address, word count) request out of a 2-cycle-latency RAM read port
// as a ready/valid stream, using a credit-checked output FIFO to absorb backpressure.
module ram_rd_stream #(
   parameter int unsigned ADDR_BITS  = 10,
   parameter int unsigned DATA_BITS  = 64,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [ADDR_BITS-1:0] req_addr,
   input  logic [ADDR_BITS:0]   req_len,
   output logic                 b_en,
   output logic [ADDR_BITS-1:0] b_addr,
   input  logic [DATA_BITS-1:0] b_data_out,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic [DATA_BITS-1:0] m_data,
   output logic                 m_last,
   output logic                 busy,
   output logic                 done
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned OCC_W = CNT_W + 1;
   localparam int unsigned LEN_W = ADDR_BITS + 1;

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

   state_t               state;
   logic [LEN_W-1:0]     remaining;
   logic                 s1_valid, s1_last, s2_valid, s2_last;
   logic [DATA_BITS-1:0] fifo_data [FIFO_DEPTH];
   logic                 fifo_last [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr, rd_ptr;
   logic [CNT_W-1:0]     fifo_count, count_nxt;
   logic [OCC_W-1:0]     occupancy;
   logic                 credit, issue, last_issue, push, pop;

   assign m_data = fifo_data[rd_ptr];
   assign m_last = m_valid && fifo_last[rd_ptr];

   // Credit counts both queued and in-flight words so landing data always has room.
   always_comb begin
      occupancy  = OCC_W'(fifo_count) + OCC_W'(s1_valid) + OCC_W'(s2_valid);
      credit     = occupancy < OCC_W'(FIFO_DEPTH);
      issue      = (state == ISSUE) && credit;
      last_issue = issue && (remaining == LEN_W'(1));
      push       = s2_valid;
      pop        = m_valid && m_ready;
      count_nxt  = fifo_count;
      if (push && !pop)
         count_nxt = fifo_count + CNT_W'(1);
      else if (!push && pop)
         count_nxt = fifo_count - CNT_W'(1);
   end

   // FIFO storage needs no reset; validity is carried by the count.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_data[wr_ptr] <= b_data_out;
         fifo_last[wr_ptr] <= s2_last;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         req_ready  <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         b_en       <= 1'b0;
         b_addr     <= '0;
         remaining  <= '0;
         s1_valid   <= 1'b0;
         s1_last    <= 1'b0;
         s2_valid   <= 1'b0;
         s2_last    <= 1'b0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         m_valid    <= 1'b0;
      end else begin
         b_en       <= 1'b1;
         done       <= 1'b0;
         s1_valid   <= issue;
         s1_last    <= last_issue;
         s2_valid   <= s1_valid;
         s2_last    <= s1_last;
         fifo_count <= count_nxt;
         m_valid    <= (count_nxt != '0);
         if (push)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)
            rd_ptr <= rd_ptr + PTR_W'(1);

         case (state)
            IDLE: begin
               req_ready <= 1'b1;
               if (req_valid && req_ready) begin
                  b_addr    <= req_addr;
                  remaining <= req_len;
                  if (req_len == '0) begin
                     done <= 1'b1;
                  end else begin
                     state     <= ISSUE;
                     req_ready <= 1'b0;
                     busy      <= 1'b1;
                  end
               end
            end
            ISSUE: begin
               if (issue) begin
                  b_addr    <= b_addr + ADDR_BITS'(1);
                  remaining <= remaining - LEN_W'(1);
                  if (last_issue)
                     state <= DRAIN;
               end
            end
            DRAIN: begin
               if (pop && m_last) begin
                  state     <= IDLE;
                  done      <= 1'b1;
                  busy      <= 1'b0;
                  req_ready <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_rd_stream.sv
// Directed bench for ram_rd_stream: RAM model preloaded with RAM[i]=i, scoreboard of
// expected beats, stream/occupancy monitor, and latency/reset/wrap scenarios.
module tb_ram_rd_stream;

   localparam int unsigned ADDR_BITS = 10;
   localparam int unsigned DATA_BITS = 64;
   localparam int unsigned DEPTH     = 1 << ADDR_BITS;

   typedef struct packed {
      logic [DATA_BITS-1:0] data;
      logic                 last;
   } beat_t;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 req_valid = 1'b0;
   logic                 req_ready;
   logic [ADDR_BITS-1:0] req_addr = '0;
   logic [ADDR_BITS:0]   req_len = '0;
   logic                 b_en;
   logic [ADDR_BITS-1:0] b_addr;
   logic [DATA_BITS-1:0] b_data_out = '0;
   logic                 m_valid;
   logic                 m_ready = 1'b1;
   logic [DATA_BITS-1:0] m_data;
   logic                 m_last;
   logic                 busy;
   logic                 done;

   int checks = 0;
   int errors = 0;
   int beats_seen = 0;
   int done_count = 0;
   beat_t sb[$];

   logic [DATA_BITS-1:0] ram [DEPTH];
   logic [DATA_BITS-1:0] ram_q = '0;
   logic                 stalled = 1'b0;
   logic [DATA_BITS-1:0] held_data = '0;
   logic                 held_last = 1'b0;

   ram_rd_stream #(.ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
      .b_en(b_en), .b_addr(b_addr), .b_data_out(b_data_out),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   initial begin
      for (int i = 0; i < int'(DEPTH); i++) ram[i] = 64'(i);
   end

   // Two-cycle read pipeline of the buffer RAM.
   always @(posedge clk) begin
      if (b_en) ram_q <= ram[b_addr];
      b_data_out <= ram_q;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Stream monitor: scoreboard compare, hold-while-stalled, credit bound.
   always @(negedge clk) begin
      if (done) done_count++;
      if (!rst) begin
         if (stalled) begin
            check("hold_valid", 64'(m_valid), 64'(1));
            check("hold_data", m_data, held_data);
            check("hold_last", 64'(m_last), 64'(held_last));
         end
         if (m_valid && m_ready) begin
            checks++;
            assert (sb.size() != 0) else begin
               errors++;
               $error("FAIL unexpected_beat: observed data 0x%0h expected no beat", m_data);
            end
            if (sb.size() != 0) begin
               beat_t e;
               e = sb.pop_front();
               check("beat_data", m_data, e.data);
               check("beat_last", 64'(m_last), 64'(e.last));
               beats_seen++;
            end
         end
         check("credit_bound",
               64'((int'(dut.fifo_count) + int'(dut.s1_valid) + int'(dut.s2_valid)) <= 4), 64'(1));
         stalled   <= m_valid && !m_ready;
         held_data <= m_data;
         held_last <= m_last;
      end else begin
         stalled <= 1'b0;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Waits for IDLE, performs one handshake, queues expected beats; returns in cycle T+1.
   task automatic do_req(input int a, input int n);
      int w = 0;
      while (!req_ready && w < 200) begin step(); w++; end
      check("req_ready_before_req", 64'(req_ready), 64'(1));
      req_addr  = ADDR_BITS'(a);
      req_len   = (ADDR_BITS+1)'(n);
      req_valid = 1'b1;
      for (int i = 0; i < n; i++) begin
         beat_t e;
         e.data = 64'((a + i) % int'(DEPTH));
         e.last = (i == n - 1);
         sb.push_back(e);
      end
      step();
      req_valid = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      bit got = 1'b0;
      for (int c = 0; c < 400 && !got; c++) begin
         step();
         if (done) got = 1'b1;
      end
      check(tag, 64'(got), 64'(1));
   endtask

   initial begin
      int d0;
      bit seen;
      // Reset values
      repeat (3) step();
      check("rst_m_valid", 64'(m_valid), 64'(0));
      check("rst_m_last", 64'(m_last), 64'(0));
      check("rst_done", 64'(done), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_b_addr", 64'(b_addr), 64'(0));
      check("rst_b_en", 64'(b_en), 64'(0));
      check("rst_req_ready", 64'(req_ready), 64'(0));
      rst = 1'b0;
      step();
      check("post_rst_req_ready", 64'(req_ready), 64'(1));
      check("post_rst_b_en", 64'(b_en), 64'(1));

      // Single beat: latency T+4, done at T+5
      do_req(5, 1);
      check("t1_busy_t1", 64'(busy), 64'(1));
      check("t1_valid_t1", 64'(m_valid), 64'(0));
      step();
      check("t1_valid_t2", 64'(m_valid), 64'(0));
      step();
      check("t1_valid_t3", 64'(m_valid), 64'(0));
      step();
      check("t1_valid_t4", 64'(m_valid), 64'(1));
      check("t1_data_t4", m_data, 64'(5));
      check("t1_last_t4", 64'(m_last), 64'(1));
      step();
      check("t1_done_t5", 64'(done), 64'(1));
      step();
      check("t1_done_pulse", 64'(done), 64'(0));
      check("t1_sb_empty", 64'(sb.size()), 64'(0));

      // 16 beats back to back, no bubbles
      do_req(0, 16);
      check("t2_busy", 64'(busy), 64'(1));
      for (int c = 0; c < 10 && !m_valid; c++) step();
      for (int i = 0; i < 16; i++) begin
         check("t2_no_bubble", 64'(m_valid), 64'(1));
         check("t2_busy_run", 64'(busy), 64'(1));
         step();
      end
      check("t2_done", 64'(done), 64'(1));
      check("t2_busy_end", 64'(busy), 64'(0));
      check("t2_req_ready", 64'(req_ready), 64'(1));
      check("t2_sb_empty", 64'(sb.size()), 64'(0));

      // Address wrap
      do_req(1020, 8);
      wait_done("t3_done");
      check("t3_sb_empty", 64'(sb.size()), 64'(0));

      // Random backpressure with one long stall
      do_req(200, 32);
      seen = 1'b0;
      for (int c = 0; c < 600 && !seen; c++) begin
         m_ready = (c >= 10 && c < 20) ? 1'b0 : 1'($urandom_range(0, 1));
         step();
         if (done) seen = 1'b1;
      end
      m_ready = 1'b1;
      check("t4_done", 64'(seen), 64'(1));
      check("t4_sb_empty", 64'(sb.size()), 64'(0));

      // Zero-length request
      d0 = beats_seen;
      do_req(7, 0);
      check("t5_done", 64'(done), 64'(1));
      check("t5_req_ready", 64'(req_ready), 64'(1));
      check("t5_busy", 64'(busy), 64'(0));
      step();
      check("t5_done_pulse", 64'(done), 64'(0));
      repeat (6) step();
      check("t5_no_beats", 64'(beats_seen), 64'(d0));

      // Reset mid-request, then a fresh request
      beats_seen = 0;
      do_req(300, 20);
      for (int c = 0; c < 100 && beats_seen < 3; c++) step();
      rst = 1'b1;
      sb.delete();
      d0 = done_count;
      step();
      check("t6_rst_m_valid", 64'(m_valid), 64'(0));
      check("t6_rst_busy", 64'(busy), 64'(0));
      check("t6_rst_req_ready", 64'(req_ready), 64'(0));
      check("t6_rst_m_last", 64'(m_last), 64'(0));
      rst = 1'b0;
      repeat (8) step();
      check("t6_no_done", 64'(done_count), 64'(d0));
      check("t6_idle_valid", 64'(m_valid), 64'(0));
      beats_seen = 0;
      do_req(100, 2);
      wait_done("t6_new_done");
      check("t6_new_beats", 64'(beats_seen), 64'(2));
      check("t6_sb_empty", 64'(sb.size()), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/ram_rd_stream.md
Name: ram_rd_stream

Overview:
- Read-side client for the on-chip block RAM buffer: converts a (start address, word count) request into sequential reads on the RAM's read-only port and emits the words as a ready/valid stream with a last marker.
- The RAM read port has fixed 2-cycle latency; this block keeps that pipeline running and uses a credit-checked output FIFO to absorb backpressure.
- Sits between the buffer RAM and the downstream packet/DMA stream logic.

Parameters:
- ADDR_BITS, 10, RAM address width; depth is 2**ADDR_BITS words.
- DATA_BITS, 64, RAM and stream data width.
- FIFO_DEPTH, 4, output FIFO entries; must be a power of two and at least 4; 4 is the minimum for full throughput.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  read request valid.
- req_ready  out  1  block can accept a request.
- req_addr  in  ADDR_BITS  first word address.
- req_len  in  ADDR_BITS+1  word count, 0..2**ADDR_BITS.
- b_en  out  1  RAM read-port enable.
- b_addr  out  ADDR_BITS  RAM read address.
- b_data_out  in  DATA_BITS  RAM read data, valid 2 cycles after address.
- m_valid  out  1  stream beat valid.
- m_ready  in  1  downstream accepts beat.
- m_data  out  DATA_BITS  stream data.
- m_last  out  1  final beat of request.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse on request completion.

Behaviour:
- Reset: the FSM goes to IDLE. FIFO is emptied and the in-flight pipe is cleared. req_ready=0 during the reset cycle and 1 afterwards. Outputs in reset: m_valid=0, m_last=0, done=0, busy=0, b_addr=0, b_en=0. b_en=1 in every non-reset cycle, so the RAM pipeline advances every cycle.
- RAM timing: an address issued in cycle t appears on b_data_out in cycle t+2. It is written into the FIFO at the end of t+2 and is visible on m_valid/m_data in t+3.
- In-flight tracking: a 2-stage shift register of {valid, last} mirrors the RAM pipeline. Stage 2 valid pushes b_data_out and its last flag into the FIFO.
- Credit: an issue is allowed only when fifo_count + inflight_count < FIFO_DEPTH. Both counts are taken before this cycle's pop and push. The FIFO can therefore never overflow.
- FSM states:
  - IDLE: req_ready=1. On req_valid && req_ready, latch addr and len.
    - If len==0: done=1 in the next cycle; stay IDLE; no beats emitted.
    - Otherwise go to ISSUE.
  - ISSUE: req_ready=0. In each cycle with credit, drive b_addr=cur_addr and push a valid into the in-flight pipe, with last set when remaining==1. Then cur_addr increments modulo 2**ADDR_BITS (wraps from max address to 0) and remaining decrements. Go to DRAIN after the last issue. In a cycle without credit, b_addr holds and nothing is pushed.
  - DRAIN: wait for m_valid && m_ready && m_last. Then done=1 in the next cycle and return to IDLE, where req_ready=1 again.
- First-beat latency: request handshake in cycle T, first issue in T+1, first m_valid in T+4.
- Throughput: with m_ready held high, one beat per cycle.
- Stream rules:
  - Once m_valid is asserted, m_data and m_last hold stable until accepted.
  - Beats come out in address order, with exactly len beats per request.
  - m_last is set only on beat len.
- Simultaneous push and pop on the FIFO are allowed; the count is unchanged in that cycle.
- Full FIFO with m_ready=0: issuing stalls, and in-flight data still lands because credit reserved room for it.
- Back-to-back requests: a new request is accepted only in IDLE, so requests never overlap.
- Reset in the middle of a request aborts it: no done pulse, and all queued and in-flight data is discarded.

Test Plan:
- Preload RAM[i]=i. Request addr=5, len=1, m_ready=1 → exactly one beat, data=5, m_last=1, m_valid in cycle T+4, done one cycle after acceptance.
- Request addr=0, len=16, m_ready=1 → 16 consecutive beats with data 0..15 and no bubbles; m_last only on data 15; busy high from T+1 until done.
- Request addr=1020, len=8, ADDR_BITS=10 → data sequence 1020,1021,1022,1023,0,1,2,3 (wrap).
- Request len=32 with m_ready toggled in a random pattern (held low for 10 cycles once) → no lost or duplicated beats, data stable while stalled, fifo_count+inflight never exceeds 4.
- Request with len=0 → no beats, done pulses once, req_ready back to 1.
- Reset asserted mid-request (after 3 beats of len=20), then a new request addr=100, len=2 → m_valid=0 after reset, no done for the aborted request, the new request yields exactly 100,101.
